// File: rtl/event_stream_reader.sv
// event_stream_reader
//   Drains a byte-wide, non-FWFT stream FIFO (VALID one cycle after RDEN),
//   buffers the bytes in a small skid buffer and emits tagged 16-bit words
//   (segment, DRS channel, start/end of event) over a ready/valid handshake.
//   Event byte layout: 32 B header, 8 x 2 B flag, 8 x 2 B stopcell,
//   8 x 4*D B DRS4 data, with channel order 0,2,4,6,1,3,5,7 in each segment.
//   Optional build macro: ESR_STRIP_HDR_EN -- header words are consumed
//   silently and TX_SOF moves to the channel-0 flag word.
module event_stream_reader #(
  parameter int SKID_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] DRS_READDEPTH,
  output logic        SFIFO_RDCLK,
  output logic        SFIFO_RDEN,
  input  logic [7:0]  SFIFO_DOUT,
  input  logic        SFIFO_EMPTY,
  input  logic        SFIFO_VALID,
  output logic [15:0] TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [1:0]  TX_SEG,
  output logic [2:0]  TX_CH,
  output logic        TX_SOF,
  output logic        TX_EOF,
  output logic [31:0] EVT_COUNT,
  output logic        FRAME_ERR
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_FLAG = 2'd1,
    ST_STOP = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // DRS channel order used inside every per-channel segment
  function automatic logic [2:0] ch_order(input logic [2:0] idx);
    logic [2:0] ch;
    case (idx)
      3'd0:    ch = 3'd0;
      3'd1:    ch = 3'd2;
      3'd2:    ch = 3'd4;
      3'd3:    ch = 3'd6;
      3'd4:    ch = 3'd1;
      3'd5:    ch = 3'd3;
      3'd6:    ch = 3'd5;
      3'd7:    ch = 3'd7;
      default: ch = 3'd0;
    endcase
    return ch;
  endfunction

  // Circular pointer increment for the skid buffer
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Skid buffer and read bookkeeping
  logic [7:0]    skid_mem [SKID_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_n1;
  logic [CW-1:0] skid_count;
  logic [CW-1:0] outstanding;
  logic [CW:0]   issue_sum;
  logic          pop;
  logic          push;
  logic          valid_dec;

  // Parser state
  state_t      state;
  state_t      state_nxt;
  logic [13:0] word_cnt;
  logic [13:0] word_cnt_nxt;
  logic [2:0]  ch_idx;
  logic [2:0]  ch_idx_nxt;
  logic [12:0] depth;
  logic [13:0] data_last;

  // Tags for the word being popped this cycle
  logic [1:0]  pair_seg;
  logic [2:0]  pair_ch;
  logic        pair_sof;
  logic        pair_eof;
  logic        pair_emit;

  assign SFIFO_RDCLK = CLK;
  assign rd_ptr_n1   = ptr_inc(rd_ptr);
  // Reads in flight + bytes held + the read issued right now must stay below
  // the skid capacity so every returning byte has a slot.
  assign issue_sum   = {1'b0, outstanding} + {1'b0, skid_count}
                     + {{CW{1'b0}}, SFIFO_RDEN};
  // A pair moves into the output register when the register is empty or
  // its current word is being taken this cycle.
  assign pop         = (skid_count >= CW'(2)) & (~TX_VALID | TX_READY);
  assign push        = SFIFO_VALID & ((skid_count < CW'(SKID_DEPTH)) | pop);
  assign valid_dec   = SFIFO_VALID & (outstanding != '0);
  // Last word index of a data channel: 2*D - 1 (14 bits hold D = 8191)
  assign data_last   = {depth, 1'b0} - 14'd1;

  // Read issue, outstanding-read tracking, skid occupancy and framing check
  always_ff @(posedge CLK) begin
    if (RST) begin
      SFIFO_RDEN  <= 1'b0;
      outstanding <= '0;
      skid_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      FRAME_ERR   <= 1'b0;
    end else begin
      SFIFO_RDEN  <= ~SFIFO_EMPTY & (issue_sum < (CW+1)'(SKID_DEPTH));
      outstanding <= outstanding + {{(CW-1){1'b0}}, SFIFO_RDEN}
                                 - {{(CW-1){1'b0}}, valid_dec};
      skid_count  <= skid_count + {{(CW-1){1'b0}}, push}
                                - {{(CW-2){1'b0}}, pop, 1'b0};
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr_n1);
      end
      if (SFIFO_VALID && (outstanding == '0)) begin
        FRAME_ERR <= 1'b1;
      end
    end
  end

  // Skid storage: bytes are written in arrival order, no reset needed
  always_ff @(posedge CLK) begin
    if (push) begin
      skid_mem[wr_ptr] <= SFIFO_DOUT;
    end
  end

  // Parser state register and readout-depth latch (taken at header word 0)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_HDR;
      word_cnt <= 14'd0;
      ch_idx   <= 3'd0;
      depth    <= 13'd0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      ch_idx   <= ch_idx_nxt;
      if (pop && (state == ST_HDR) && (word_cnt == 14'd0)) begin
        depth <= DRS_READDEPTH;
      end
    end
  end

  // Parser next state and tags of the word popped this cycle
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    ch_idx_nxt   = ch_idx;
    pair_seg     = state;
    pair_ch      = 3'd0;
    pair_sof     = 1'b0;
    pair_eof     = 1'b0;
    pair_emit    = 1'b1;
    case (state)
      ST_HDR: begin
`ifdef ESR_STRIP_HDR_EN
        pair_emit = 1'b0;
        pair_sof  = 1'b0;
`else
        pair_emit = 1'b1;
        pair_sof  = (word_cnt == 14'd0);
`endif
        if (pop) begin
          if (word_cnt == 14'd15) begin
            state_nxt    = ST_FLAG;
            word_cnt_nxt = 14'd0;
          end else begin
            word_cnt_nxt = word_cnt + 14'd1;
          end
        end else begin
          word_cnt_nxt = word_cnt;
        end
      end
      ST_FLAG: begin
        pair_ch = ch_order(ch_idx);
`ifdef ESR_STRIP_HDR_EN
        pair_sof = (ch_idx == 3'd0);
`else
        pair_sof = 1'b0;
`endif
        if (pop) begin
          if (ch_idx == 3'd7) begin
            state_nxt  = ST_STOP;
            ch_idx_nxt = 3'd0;
          end else begin
            ch_idx_nxt = ch_idx + 3'd1;
          end
        end else begin
          ch_idx_nxt = ch_idx;
        end
      end
      ST_STOP: begin
        pair_ch  = ch_order(ch_idx);
        // With zero depth the event ends on the last stopcell word
        pair_eof = (ch_idx == 3'd7) && (depth == 13'd0);
        if (pop) begin
          if (ch_idx == 3'd7) begin
            ch_idx_nxt = 3'd0;
            state_nxt  = (depth == 13'd0) ? ST_HDR : ST_DATA;
          end else begin
            ch_idx_nxt = ch_idx + 3'd1;
          end
        end else begin
          ch_idx_nxt = ch_idx;
        end
      end
      ST_DATA: begin
        pair_ch  = ch_order(ch_idx);
        pair_eof = (ch_idx == 3'd7) && (word_cnt == data_last);
        if (pop) begin
          if (word_cnt == data_last) begin
            word_cnt_nxt = 14'd0;
            if (ch_idx == 3'd7) begin
              state_nxt  = ST_HDR;
              ch_idx_nxt = 3'd0;
            end else begin
              ch_idx_nxt = ch_idx + 3'd1;
            end
          end else begin
            word_cnt_nxt = word_cnt + 14'd1;
          end
        end else begin
          word_cnt_nxt = word_cnt;
        end
      end
      default: begin
        state_nxt    = ST_HDR;
        word_cnt_nxt = 14'd0;
        ch_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Output word register: loads a popped pair, holds while stalled
  always_ff @(posedge CLK) begin
    if (RST) begin
      TX_DATA  <= 16'd0;
      TX_VALID <= 1'b0;
      TX_SEG   <= 2'd0;
      TX_CH    <= 3'd0;
      TX_SOF   <= 1'b0;
      TX_EOF   <= 1'b0;
    end else if (pop && pair_emit) begin
      TX_DATA  <= {skid_mem[rd_ptr], skid_mem[rd_ptr_n1]};
      TX_VALID <= 1'b1;
      TX_SEG   <= pair_seg;
      TX_CH    <= pair_ch;
      TX_SOF   <= pair_sof;
      TX_EOF   <= pair_eof;
    end else if (TX_READY) begin
      TX_VALID <= 1'b0;
      TX_SOF   <= 1'b0;
      TX_EOF   <= 1'b0;
    end
  end

  // Completed-event counter, stepped when the EOF word is accepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      EVT_COUNT <= 32'd0;
    end else if (TX_VALID && TX_READY && TX_EOF) begin
      EVT_COUNT <= EVT_COUNT + 32'd1;
    end
  end

endmodule
